div_unit_r32i: RTL
==================

DIV_UNIT_R32I -- requirements
Module: div_unit_r32i

Interface
REQ-001 SHALL have parameter dataW, default 32, operand/result width.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-005 SHALL have port op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
REQ-006 SHALL have port A  input  dataW  dividend.
REQ-007 SHALL have port B  input  dataW  divisor.
REQ-008 SHALL have port busy  output  1  high from the edge after accept until the edge before done.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port result  output  dataW  quotient or remainder, held until the next accept.

Function
REQ-011 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; DONE lasts exactly one cycle.
REQ-012 SHALL capture op, A and B on the accept edge; later input changes have no effect on the operation.
REQ-013 SHALL ignore start while busy=1 or done=1.
REQ-014 SHALL perform one restoring-division step per BUSY cycle on operand magnitudes, 32 steps for dataW=32.
REQ-015 SHALL raise done 33 cycles after the accept edge (accept at edge N -> done=1 after edge N+33), with busy=1 over edges N+1..N+32.
REQ-016 SHALL truncate signed quotients toward zero; the signed remainder takes the sign of the dividend.
REQ-017 SHALL treat A and B as unsigned for DIVU and REMU.
REQ-018 SHALL, for divide-by-zero, return all ones for DIV/DIVU and A for REM/REMU.
REQ-019 SHALL, for signed overflow (A=0x80000000, B=-1), return 0x80000000 for DIV and 0 for REM.
REQ-020 SHALL allow start in the same cycle as done=0 following DONE, so the next accept is at the edge after DONE.

Reset
REQ-021 SHALL, when reset=1 at an edge, set state IDLE, busy=0, done=0, result=0 and clear internal registers.
REQ-022 SHALL give reset priority over start, including mid-operation, and SHALL emit no done for an aborted operation.

Configuration
REQ-023 SHALL support macro DIV_EARLY_OUT_EN.
REQ-024 SHALL, with DIV_EARLY_OUT_EN defined, complete divide-by-zero and signed overflow without entering BUSY: done=1 after edge N+1, busy never high.
REQ-025 SHALL, without DIV_EARLY_OUT_EN, use the fixed 33-cycle latency for every operation, special cases included.

Structure
REQ-026 SHALL take the op encodings and the FSM state typedef from shared package div_pkg_r32i, alongside the existing ALU codes.
REQ-027 SHALL place one combinational shift/subtract iteration in sub-module divstep_r32i (inputs: remainder, quotient, divisor; outputs: next remainder, next quotient).
REQ-028 SHALL be implementable in 120-400 lines of RTL with no multi-cycle combinational paths.

Verification
REQ-029 SHALL test: DIV A=20 B=6 -> result=3, done exactly 33 cycles after accept; REM A=-20 B=6 -> result=-2; DIV A=-20 B=6 -> result=-3.
REQ-030 SHALL test: DIVU A=0xFFFFFFFF B=2 -> result=0x7FFFFFFF; REMU A=0xFFFFFFFF B=2 -> result=1.
REQ-031 SHALL test: DIV A=7 B=0 -> result=0xFFFFFFFF; REM A=7 B=0 -> result=7; latency 1 cycle with DIV_EARLY_OUT_EN and 33 cycles without.
REQ-032 SHALL test: DIV A=0x80000000 B=-1 -> result=0x80000000; REM A=0x80000000 B=-1 -> result=0.
REQ-033 SHALL test: reset asserted 10 cycles after accept -> busy=0, done=0, result=0 on the next edge, and no done pulse follows.
REQ-034 SHALL test: start with A=100 B=7 while busy -> ignored; first operation's result unchanged; A and B changed mid-operation -> no effect.

Source files
------------

// File: rtl/div_pkg_r32i.sv
// Shared codes for the integer datapath: ALU op codes, divider op codes and divider FSM states.
package div_pkg_r32i;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  // ST_EARLY is only reachable when the early-out build option is enabled.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_EARLY = 2'd3
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e o);
    return (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e o);
    return (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/divstep_r32i.sv
// One restoring-division iteration: shift the dividend MSB into the remainder, trial-subtract the divisor.
module divstep_r32i #(
  parameter int dataW = 32
) (
  input  logic [dataW-1:0] rem_i,
  input  logic [dataW-1:0] quo_i,
  input  logic [dataW-1:0] dvsr_i,
  output logic [dataW-1:0] rem_o,
  output logic [dataW-1:0] quo_o
);

  logic [dataW:0] rem_sh;

  always_comb begin
    rem_sh = {rem_i, quo_i[dataW-1]};
    // When the subtraction succeeds the true difference is below 2^dataW, so the low bits are exact.
    if (rem_sh >= {1'b0, dvsr_i}) begin
      rem_o = rem_sh[dataW-1:0] - dvsr_i;
      quo_o = {quo_i[dataW-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[dataW-1:0];
      quo_o = {quo_i[dataW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit_r32i.sv
// Iterative signed/unsigned divider (DIV/DIVU/REM/REMU), one restoring step per BUSY cycle.
// Build option DIV_EARLY_OUT_EN: finish divide-by-zero and signed overflow without the BUSY phase.
module div_unit_r32i
  import div_pkg_r32i::*;
#(
  parameter int dataW = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [dataW-1:0] A,
  input  logic [dataW-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [dataW-1:0] result
);

  localparam int CntW = $clog2(dataW + 1);
  localparam logic [CntW-1:0]  STEPS   = CntW'(dataW);
  localparam logic [dataW-1:0] MIN_NEG = {1'b1, {(dataW-1){1'b0}}};

  div_state_e       state_q;
  div_op_e          op_q;
  logic [dataW-1:0] dvsr_q, rem_q, quo_q, spec_res_q, result_q;
  logic [CntW-1:0]  cnt_q;
  logic             neg_quo_q, neg_rem_q, special_q, busy_q, done_q;

  div_op_e          op_in;
  logic             sgn_in, a_neg, b_neg, dz_in, ovf_in;
  logic [dataW-1:0] a_mag, b_mag, spec_res_in;
  logic [dataW-1:0] rem_d, quo_d, quo_fix, rem_fix, final_res;

  always_comb begin
    op_in  = div_op_e'(op);
    sgn_in = op_is_signed(op_in);
    a_neg  = sgn_in & A[dataW-1];
    b_neg  = sgn_in & B[dataW-1];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    dz_in  = (B == '0);
    ovf_in = sgn_in && (A == MIN_NEG) && (B == '1);
    if (dz_in) spec_res_in = op_is_rem(op_in) ? A : '1;
    else       spec_res_in = op_is_rem(op_in) ? '0 : MIN_NEG;
  end

  divstep_r32i #(.dataW(dataW)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvsr_i(dvsr_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_comb begin
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
    final_res = special_q ? spec_res_q : (op_is_rem(op_q) ? rem_fix : quo_fix);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_DIV;
      dvsr_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      spec_res_q <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      special_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q       <= op_in;
            dvsr_q     <= b_mag;
            rem_q      <= '0;
            quo_q      <= a_mag;
            cnt_q      <= STEPS;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            special_q  <= dz_in | ovf_in;
            spec_res_q <= spec_res_in;
`ifdef DIV_EARLY_OUT_EN
            if (dz_in || ovf_in) begin
              state_q <= ST_EARLY;
            end else begin
              state_q <= ST_BUSY;
              busy_q  <= 1'b1;
            end
`else
            state_q <= ST_BUSY;
            busy_q  <= 1'b1;
`endif
          end
        end
        ST_BUSY: begin
          if (cnt_q != '0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // All steps done; this cycle applies the sign fix-up and special-case override.
            result_q <= final_res;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_EARLY: begin
          result_q <= spec_res_q;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
